uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter; the upstream partner of the UART receiver on the serial line.
//  Accepts a byte over a four-phase Send/Sent handshake and serialises it on Tx:
//  start(0), 8 data bits LSB first, optional odd parity bit, stop(1).
//  With parity enabled, a loopback into the receiver gives Dout==Din and parityErr=0.
// PARAMETERS
//  BIT_CYCLES  5209  clk cycles per serial bit (19200 baud @ 100 MHz); range 4..8191
// PORTS
//  clk    in   1  system clock; all logic on posedge clk
//  Reset  in   1  synchronous, active-high reset
//  Send   in   1  request; sampled only in IDLE
//  Din    in   8  byte to send; captured on the cycle Send is accepted
//  Tx     out  1  serial line, registered; idles high
//  Sent   out  1  frame complete; held until Send deasserts
//  Busy   out  1  high whenever state != IDLE
// BEHAVIOUR
//  - Reset (sync, active-high): next edge -> state IDLE, Tx=1, Sent=0, Busy=0, timer=0, bit count=0.
//    Reset mid-frame aborts immediately; Tx returns to 1 the next cycle; no partial Sent.
//  - Baud timer counts 0..BIT_CYCLES-1. bitDone = (count==BIT_CYCLES-1); wraps to 0 and is cleared on state entry.
//    Every serial bit lasts exactly BIT_CYCLES cycles on Tx.
//  - FSM: IDLE -> START -> BITS -> [PAR] -> STOP -> ACK -> IDLE.
//    IDLE: Tx=1. Send=1 at edge k -> latch Din into shift reg, compute parity bit = ~^Din, go START.
//          Tx=0 from cycle k+1 (one-cycle latency).
//    START: Tx=0; on bitDone -> BITS with bit index 0.
//    BITS: Tx=shift[0]; on bitDone: if index==7 -> PAR (or STOP if parity disabled);
//          else shift right and index+1.
//    PAR: Tx=parity bit; on bitDone -> STOP.
//    STOP: Tx=1; on bitDone -> ACK.
//    ACK: Tx=1, Sent=1. Send==0 -> IDLE (Sent=0 next cycle); Send held high -> stay in ACK.
//  - Send/Din changes while Busy are ignored; the byte in flight is unaffected.
//  - A new frame cannot start until Send has been low at least one cycle (no back-to-back without release).
//  - Reset has priority over Send when both are asserted in the same cycle.
//  - Frame length (Send accept to Sent=1): 11*BIT_CYCLES cycles with parity, 10*BIT_CYCLES without.
//  - Tx is driven directly from a flop; no combinational path from Send or Din to Tx.
// CONFIGURATION
//  Macro UART_TX_PARITY_EN:
//   defined: PAR state present; 11-bit frame with odd parity (ones in data+parity are odd);
//            frame matches the receiver.
//   undefined: PAR state and parity logic compiled out; 10-bit 8N1 frame; BITS goes straight to STOP.
// STRUCTURE
//  Package uart_pkg: tx_state_t enum {IDLE,START,BITS,PAR,STOP,ACK}, DEFAULT_BIT_CYCLES=5209,
//  function odd_parity(logic[7:0]) (shared with the receiver's parity check).
//  Sub-module baud_timer #(BIT_CYCLES) (clk, Reset, clr, done); the receiver may reuse it.
//  Top level holds the FSM, 8-bit shift register, 3-bit bit index, parity flop and Tx flop.
// TESTING (BIT_CYCLES=16 for speed unless noted; parity enabled unless noted)
//  1. Din=8'h41, pulse Send -> Tx bits 0,1,0,0,0,0,0,1,0,1(par),1(stop), each 16 cycles;
//     Sent=1 at 176 cycles after accept.
//  2. Din=8'h07 -> parity bit 0; Din=8'h00 and 8'hFF -> parity bit 1.
//  3. Send held high through ACK -> Sent stays 1 and no second frame; drop Send -> IDLE next cycle, Sent=0.
//  4. Change Din to 8'hAA mid-frame while sending 8'h55 -> line still carries 8'h55.
//  5. Assert Reset during data bit 3 -> next cycle Tx=1, Busy=0, Sent=0; a following Send of 8'h3C completes normally.
//  6. Loopback into the receiver, BIT_CYCLES=5209, bytes 8'h00/8'hA5/8'hFF -> Dout matches Din, parityErr=0;
//     with UART_TX_PARITY_EN undefined, Tx frame is 160 cycles at BIT_CYCLES=16.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types, defaults and parity helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_BIT_CYCLES = 5209;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BITS  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    ACK   = 3'd5
  } tx_state_t;

  // Odd parity: the returned bit makes the count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// uart_tx_if : Send/Sent handshake, data byte and serial line of the transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_tx_if;
  logic       Send;
  logic [7:0] Din;
  logic       Tx;
  logic       Sent;
  logic       Busy;

  modport master (output Send, Din, input Tx, Sent, Busy);
  modport slave  (input Send, Din, output Tx, Sent, Busy);
endinterface

`default_nettype wire

// File: rtl/baud_timer.sv
// ============================================================================
// baud_timer : counts 0..BIT_CYCLES-1, flags the last cycle of each serial bit
// Rev 1.0
// ============================================================================
`default_nettype none

module baud_timer
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  output logic done
);

  logic [12:0] count;

  assign done = (count == 13'(BIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (Reset || clr || done) begin
      count <= 13'd0;
    end else begin
      count <= count + 13'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : UART transmitter, start + 8 data bits LSB first + [odd parity] + stop
// Optional parity bit enabled by macro UART_TX_PARITY_EN (8N1 when undefined).
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic     clk,
  input  logic     Reset,
  uart_tx_if.slave bus
);

  tx_state_t  state, state_next;
  logic [7:0] shift, shift_next;
  logic [2:0] idx, idx_next;
  logic       tx_q, tx_next;
  logic       sent_q;
  logic       bit_done;
  logic       timer_clr;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_next;
`endif

  baud_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk   (clk),
    .Reset (Reset),
    .clr   (timer_clr),
    .done  (bit_done)
  );

  always_comb begin
    state_next = state;
    shift_next = shift;
    idx_next   = idx;
`ifdef UART_TX_PARITY_EN
    par_next   = par_q;
`endif
    case (state)
      IDLE: if (bus.Send) begin
        state_next = START;
        shift_next = bus.Din;
        idx_next   = 3'd0;
`ifdef UART_TX_PARITY_EN
        par_next   = odd_parity(bus.Din);
`endif
      end
      START: if (bit_done) begin
        state_next = BITS;
        idx_next   = 3'd0;
      end
      BITS: if (bit_done) begin
        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PAR;
`else
          state_next = STOP;
`endif
        end else begin
          shift_next = shift >> 1;
          idx_next   = idx + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PAR:  if (bit_done) state_next = STOP;
`endif
      STOP: if (bit_done) state_next = ACK;
      ACK:  if (!bus.Send) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Restart the bit timer on every state change so each bit is a full period.
    timer_clr = (state_next != state);

    // Line level is computed from the next state so Tx comes straight off a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      BITS:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PAR:     tx_next = par_q;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= IDLE;
      shift  <= 8'd0;
      idx    <= 3'd0;
      tx_q   <= 1'b1;
      sent_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      shift  <= shift_next;
      idx    <= idx_next;
      tx_q   <= tx_next;
      sent_q <= (state_next == ACK);
`ifdef UART_TX_PARITY_EN
      par_q  <= par_next;
`endif
    end
  end

  assign bus.Tx   = tx_q;
  assign bus.Sent = sent_q;
  assign bus.Busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// tb_uart_tx : directed + random frames checked against a bit-list model of the UART frame
// Rev 1.1
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int C_BC          = 16;
    localparam int C_TIMEOUT_CYC = 200000;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   r_done = 1'b0;

    uart_tx_if bus ();

    uart_tx #(.BIT_CYCLES(C_BC)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin : g_watchdog
        int n;
        n = 0;
        while (!r_done && n < C_TIMEOUT_CYC) begin
            @(posedge clk);
            n++;
        end
        if (!r_done) begin
            bad++;
            $error("FAIL timeout: test did not finish within %0d cycles", C_TIMEOUT_CYC);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic run_frame(input logic [7:0] b, input bit hold,
                             input int abort_at, input int change_at);
        logic exp_bits[$];
        int   cyc;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(($countones(b) % 2) == 0);
`endif
        exp_bits.push_back(1'b1);

        check("idle_before", bus.Busy, 1'b0);
        @(negedge clk);
        bus.Send = 1'b1;
        bus.Din  = b;
        @(posedge clk);
        cyc = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            for (int c = 0; c < C_BC; c++) begin
                @(negedge clk);
                if (cyc == 0 && !hold) bus.Send = 1'b0;
                if (cyc == change_at) bus.Din = 8'hAA;
                if (cyc == abort_at) begin
                    Reset = 1'b1;
                    @(negedge clk);
                    Reset = 1'b0;
                    check("abort_tx", bus.Tx, 1'b1);
                    check("abort_busy", bus.Busy, 1'b0);
                    check("abort_sent", bus.Sent, 1'b0);
                    return;
                end
                check($sformatf("tx b%0h bit%0d", b, i), bus.Tx, exp_bits[i]);
                check("busy_in_frame", bus.Busy, 1'b1);
                check("sent_in_frame", bus.Sent, 1'b0);
                cyc++;
            end
        end
        @(negedge clk);
        check($sformatf("sent_at_%0d", cyc), bus.Sent, 1'b1);
        check("ack_tx", bus.Tx, 1'b1);
        if (hold) begin
            for (int i = 0; i < 3 * C_BC; i++) begin
                @(negedge clk);
                check("hold_sent", bus.Sent, 1'b1);
                check("hold_tx", bus.Tx, 1'b1);
                check("hold_busy", bus.Busy, 1'b1);
            end
            bus.Send = 1'b0;
        end
        @(negedge clk);
        check("release_sent", bus.Sent, 1'b0);
        check("release_busy", bus.Busy, 1'b0);
    endtask

    initial begin
        bus.Send = 1'b0;
        bus.Din  = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if (bus.Tx !== 1'b1 || bus.Sent !== 1'b0 || bus.Busy !== 1'b0) begin
            bad++;
            $error("FAIL reset state: Tx=%0b Sent=%0b Busy=%0b (expected 1/0/0)",
                   bus.Tx, bus.Sent, bus.Busy);
        end
        check("rst_tx", bus.Tx, 1'b1);
        check("rst_sent", bus.Sent, 1'b0);
        check("rst_busy", bus.Busy, 1'b0);
        Reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(8'h41, 1'b0, -1, -1);
        run_frame(8'h07, 1'b0, -1, -1);
        run_frame(8'h00, 1'b0, -1, -1);
        run_frame(8'hFF, 1'b0, -1, -1);
        run_frame(8'h5A, 1'b1, -1, -1);
        run_frame(8'h55, 1'b0, -1, 50);
        run_frame(8'h55, 1'b0, 4 * C_BC + 5, -1);
        run_frame(8'h3C, 1'b0, -1, -1);

        @(negedge clk);
        Reset    = 1'b1;
        bus.Send = 1'b1;
        bus.Din  = 8'h81;
        @(negedge clk);
        Reset    = 1'b0;
        bus.Send = 1'b0;
        check("rst_vs_send_busy", bus.Busy, 1'b0);
        check("rst_vs_send_tx", bus.Tx, 1'b1);
        @(negedge clk);
        check("rst_vs_send_idle", bus.Busy, 1'b0);

        for (int n = 0; n < 6; n++) begin
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), -1,
                      int'($urandom_range(0, 8 * C_BC)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        r_done = 1'b1;
        if (bad != 0) $error("FAIL summary: %0d of %0d checks failed", bad, total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
